// File: rtl/if_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// if_prefetch_pkg
// Shared constants for the instruction-fetch front end.
//   RESET_PC_DEFAULT : first fetch address after reset (default value)
//   INST_BYTES       : size of one instruction word in bytes
//   ALIGN_LSB_MASK   : low address bits that must be zero for an aligned word
// ---------------------------------------------------------------------------
package if_prefetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_BYTES       = 4;
    localparam int          ALIGN_LSB_MASK   = INST_BYTES - 1;

endpackage : if_prefetch_pkg

// File: rtl/if_inst_fifo.sv
// ---------------------------------------------------------------------------
// if_inst_fifo
// Synchronous FIFO holding prefetched {addr, inst} entries.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : empties the FIFO; wins over push and pop
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : remove the head entry
//   head_data  : current head entry (not masked when empty)
//   count      : number of entries held (0..DEPTH)
//   empty      : count == 0
// ---------------------------------------------------------------------------
module if_inst_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage array: no reset needed, entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap naturally on overflow of their width.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

endmodule : if_inst_fifo

// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch front end: PC generation, one ROM read per cycle with a
// fixed one-cycle latency, a DEPTH-entry prefetch queue drained by IF/ID, and
// jump redirect that flushes the queue and the in-flight read.
//   clk, rst     : clock, synchronous active-high reset
//   rom_req_o    : ROM read request this cycle
//   rom_addr_o   : ROM read address (word aligned)
//   rom_rdata_i  : ROM data, valid one cycle after a request
//   jump_en_i    : redirect from execute
//   jump_addr_i  : redirect target (low two bits ignored)
//   inst_valid_o : queue head valid toward IF/ID
//   inst_ready_i : IF/ID accepts the head
//   inst_o       : head instruction (0 when not valid)
//   inst_addr_o  : head instruction address (0 when not valid)
// ---------------------------------------------------------------------------
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_rdata_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_ALIGN_MASK = ~ADDR_W'(ALIGN_LSB_MASK);
    localparam logic [ADDR_W-1:0] ADDR_STEP       = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0]        pc_q;
    logic                     infl_q;
    logic [ADDR_W-1:0]        infl_addr_q;

    logic [ADDR_W+INST_W-1:0] head_data;
    logic [CNT_W-1:0]         count;
    logic                     empty;
    logic                     pop;
    logic                     push;
    logic                     issue_ok;
    logic [OCC_W-1:0]         occupancy;
    logic [ADDR_W-1:0]        jump_target;

    if_inst_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (jump_en_i),
        .push      (push),
        .push_data ({infl_addr_q, rom_rdata_i}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .empty     (empty)
    );

    // Head visibility: hidden during reset and jump cycles, so no pop can
    // happen while the queue is being flushed.
    always_comb begin
        inst_valid_o = !rst && !jump_en_i && !empty;
        pop          = inst_valid_o && inst_ready_i;
        inst_addr_o  = inst_valid_o ? head_data[ADDR_W+INST_W-1:INST_W] : '0;
        inst_o       = inst_valid_o ? head_data[INST_W-1:0] : '0;
    end

    // Issue rule: entries left after this cycle's pop, plus the word about
    // to land, must leave room for one more response next cycle.
    always_comb begin
        occupancy   = OCC_W'(count) + OCC_W'(infl_q) - OCC_W'(pop);
        issue_ok    = occupancy < OCC_W'(DEPTH);
        jump_target = jump_addr_i & ADDR_ALIGN_MASK;
    end

    // Request side with reset over jump over normal sequencing; a jump
    // always issues its target immediately so there is no request bubble.
    always_comb begin
        rom_req_o  = 1'b0;
        rom_addr_o = RESET_PC;
        if (rst) begin
            rom_req_o  = 1'b0;
            rom_addr_o = RESET_PC;
        end else if (jump_en_i) begin
            rom_req_o  = 1'b1;
            rom_addr_o = jump_target;
        end else begin
            rom_req_o  = issue_ok;
            rom_addr_o = pc_q;
        end
    end

    // A response is only kept if a read is outstanding and no jump is
    // discarding it this cycle.
    assign push = infl_q && !jump_en_i && !rst;

    // PC and in-flight tracking. Address arithmetic wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            infl_q      <= 1'b0;
            infl_addr_q <= RESET_PC;
        end else begin
            infl_q      <= rom_req_o;
            infl_addr_q <= rom_addr_o;
            if (rom_req_o) begin
                pc_q <= rom_addr_o + ADDR_STEP;
            end
        end
    end

endmodule : if_prefetch

// File: tb/tb_if_prefetch.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch
// Drives three prefetchers (DEPTH 4, 2 and 8) with shared reset/jump/ready
// stimulus. Each has its own ROM returning addr ^ 32'hA5A5_0000 one cycle
// after a request, and its own queue-level reference model.
// ---------------------------------------------------------------------------
module tb_if_prefetch;

    localparam int          NDUT    = 3;
    localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic jumpEn = 1'b0;
    logic instReady = 1'b0;
    logic [31:0] jumpAddr = 32'h0;

    logic [NDUT-1:0]       romReq;
    logic [NDUT-1:0][31:0] romAddr;
    logic [NDUT-1:0][31:0] romData;
    logic [NDUT-1:0]       instValid;
    logic [NDUT-1:0][31:0] instData;
    logic [NDUT-1:0][31:0] instAddr;

    int checks = 0;
    int failures = 0;
    bit countReqs = 0;
    int reqCount = 0;

    // Reference model state, one slot per DUT: a plain address queue.
    logic [31:0] mPc[NDUT];
    logic [31:0] mInflAddr[NDUT];
    bit          mInfl[NDUT];
    int          mCnt[NDUT];
    logic [31:0] mQ[NDUT][8];

    // Free-running clock
    always #5 clk = ~clk;

    function automatic int depthOf(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    // One DUT plus its ROM per depth; the ROM returns noise when idle so a
    // spurious push shows up as a wrong instruction word.
    generate
        for (genvar g = 0; g < NDUT; g++) begin : gDut
            localparam int DEP = (g == 0) ? 4 : ((g == 1) ? 2 : 8);

            if_prefetch #(
                .ADDR_W   (32),
                .INST_W   (32),
                .DEPTH    (DEP),
                .RESET_PC (32'h0)
            ) dut (
                .clk          (clk),
                .rst          (rst),
                .rom_req_o    (romReq[g]),
                .rom_addr_o   (romAddr[g]),
                .rom_rdata_i  (romData[g]),
                .jump_en_i    (jumpEn),
                .jump_addr_i  (jumpAddr),
                .inst_valid_o (instValid[g]),
                .inst_ready_i (instReady),
                .inst_o       (instData[g]),
                .inst_addr_o  (instAddr[g])
            );

            always @(posedge clk) begin
                romData[g] <= romReq[g] ? (romAddr[g] ^ ROM_KEY) : $urandom;
            end
        end
    endgenerate

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected outputs for this cycle, comparison, then model advance.
    task automatic modelCycle(input int k);
        logic        expReq, expValid, doPop;
        logic [31:0] expAddr, expIAddr, expInst, target;
        int          occ;
        expReq   = 1'b0;
        expValid = 1'b0;
        doPop    = 1'b0;
        expAddr  = 32'h0;
        expIAddr = 32'h0;
        expInst  = 32'h0;
        target   = jumpAddr & 32'hFFFF_FFFC;
        if (rst) begin
            expReq = 1'b0;
        end else if (jumpEn) begin
            expReq  = 1'b1;
            expAddr = target;
        end else begin
            expValid = (mCnt[k] > 0);
            if (expValid) begin
                expIAddr = mQ[k][0];
                expInst  = mQ[k][0] ^ ROM_KEY;
            end
            doPop   = expValid && instReady;
            occ     = mCnt[k] - (doPop ? 1 : 0) + (mInfl[k] ? 1 : 0);
            expReq  = (occ < depthOf(k));
            expAddr = mPc[k];
        end

        checkOutput($sformatf("d%0d.rom_req", k), 32'(romReq[k]), 32'(expReq));
        checkOutput($sformatf("d%0d.rom_addr", k), romAddr[k], expAddr);
        checkOutput($sformatf("d%0d.inst_valid", k), 32'(instValid[k]), 32'(expValid));
        checkOutput($sformatf("d%0d.inst_addr", k), instAddr[k], expIAddr);
        checkOutput($sformatf("d%0d.inst", k), instData[k], expInst);
        if (k == 0 && countReqs && romReq[0]) reqCount++;

        if (rst) begin
            mCnt[k]  = 0;
            mInfl[k] = 1'b0;
            mPc[k]   = 32'h0;
        end else if (jumpEn) begin
            mCnt[k]      = 0;
            mInfl[k]     = 1'b1;
            mInflAddr[k] = target;
            mPc[k]       = target + 32'd4;
        end else begin
            if (doPop) begin
                for (int i = 0; i < 7; i++) mQ[k][i] = mQ[k][i + 1];
                mCnt[k]--;
            end
            if (mInfl[k] && mCnt[k] < 8) begin
                mQ[k][mCnt[k]] = mInflAddr[k];
                mCnt[k]++;
            end
            mInfl[k]     = expReq;
            mInflAddr[k] = expAddr;
            if (expReq) mPc[k] = expAddr + 32'd4;
        end
    endtask

    // Drive one cycle of inputs after the falling edge, check once settled,
    // then let the rising edge commit.
    task automatic applyStimulus(input logic r, input logic j,
                                 input logic [31:0] ja, input logic rdy);
        @(negedge clk);
        rst       = r;
        jumpEn    = j;
        jumpAddr  = ja;
        instReady = rdy;
        #1;
        for (int k = 0; k < NDUT; k++) modelCycle(k);
        @(posedge clk);
    endtask

    // Directed scenarios followed by random stress, then the summary.
    initial begin
        for (int k = 0; k < NDUT; k++) begin
            mPc[k] = 32'h0; mInfl[k] = 1'b0; mCnt[k] = 0; mInflAddr[k] = 32'h0;
        end

        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        countReqs = 1;
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        countReqs = 0;
        checkOutput("stall_request_count", 32'(reqCount), 32'd4);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'h203, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            logic        r, j, rdy;
            logic [31:0] ja;
            r   = ($urandom_range(0, 199) == 0);
            j   = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            ja  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                              : ($urandom & 32'h0000_0FFF);
            applyStimulus(r, j, ja, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_prefetch
